// File: rtl/sys_mem_arb_if.sv
// Agent-side and memory-side bus of the shared memory arbiter.
// The arbiter connects through the slave modport; the requesting side
// (agents plus memory model) uses the master modport.
interface sys_mem_arb_if #(
    parameter int NUM_AGENTS     = 4,
    parameter int SYS_MEM_DATA_W = 32,
    parameter int SYS_MEM_ADDR_W = 27
);
    logic [NUM_AGENTS-1:0]                agent_wren;
    logic [NUM_AGENTS-1:0]                agent_rden;
    logic [NUM_AGENTS*SYS_MEM_ADDR_W-1:0] agent_addr;
    logic [NUM_AGENTS*SYS_MEM_DATA_W-1:0] agent_wdata;
    logic [NUM_AGENTS-1:0]                agent_wait;
    logic [NUM_AGENTS-1:0]                agent_rd_valid;
    logic [SYS_MEM_DATA_W-1:0]            agent_rdata;

    logic                                 sys_mem_wait;
    logic                                 sys_mem_wren;
    logic                                 sys_mem_rden;
    logic [SYS_MEM_ADDR_W-1:0]            sys_mem_addr;
    logic [SYS_MEM_DATA_W-1:0]            sys_mem_wdata;
    logic                                 sys_mem_rd_valid;
    logic [SYS_MEM_DATA_W-1:0]            sys_mem_rdata;

    modport slave (
        input  agent_wren, agent_rden, agent_addr, agent_wdata,
        input  sys_mem_wait, sys_mem_rd_valid, sys_mem_rdata,
        output agent_wait, agent_rd_valid, agent_rdata,
        output sys_mem_wren, sys_mem_rden, sys_mem_addr, sys_mem_wdata
    );

    modport master (
        output agent_wren, agent_rden, agent_addr, agent_wdata,
        output sys_mem_wait, sys_mem_rd_valid, sys_mem_rdata,
        input  agent_wait, agent_rd_valid, agent_rdata,
        input  sys_mem_wren, sys_mem_rden, sys_mem_addr, sys_mem_wdata
    );
endinterface

// File: rtl/sys_mem_arb.sv
// Round-robin arbiter sharing one memory port among NUM_AGENTS agents.
// Each transfer takes an IDLE (arbitrate) cycle then one or more GRANT cycles.
// Read returns come back in order; a tag FIFO remembers which agent owns each.
// The bus interface must be instantiated with the same NUM_AGENTS / widths.
module sys_mem_arb #(
    parameter int NUM_AGENTS     = 4,
    parameter int SYS_MEM_DATA_W = 32,
    parameter int SYS_MEM_ADDR_W = 27,
    parameter int RD_TAG_DEPTH   = 8,
    localparam int TAG_W         = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1,
    localparam int PTR_W         = $clog2(RD_TAG_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    sys_mem_arb_if.slave     bus,
    output logic [PTR_W:0]   rd_outstanding,
    output logic             rd_err
);

    localparam logic [0:0]     IDLE     = 1'b0;
    localparam logic [0:0]     GRANT    = 1'b1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RD_TAG_DEPTH);

    logic [0:0]                state, state_nxt;
    logic [TAG_W-1:0]          gnt, gnt_nxt;
    logic [TAG_W-1:0]          last_gnt, last_gnt_nxt;

    logic [NUM_AGENTS-1:0]     eligible;
    logic                      found;
    logic [TAG_W-1:0]          pick, cand;

    logic                      in_grant, req_wr, req_rd, cmd_rd;
    logic                      xfer_done, abort;
    logic [SYS_MEM_ADDR_W-1:0] gnt_addr, addr_hold;
    logic [SYS_MEM_DATA_W-1:0] gnt_wdata, wdata_hold;

    logic [TAG_W-1:0]          tag_mem [RD_TAG_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      push, pop;

    assign in_grant  = (state == GRANT);
    assign req_wr    = bus.agent_wren[gnt];
    assign req_rd    = bus.agent_rden[gnt];
    assign cmd_rd    = req_rd & ~req_wr;   // write wins when both are asserted
    assign xfer_done = in_grant & (req_wr | req_rd) & ~bus.sys_mem_wait;
    assign abort     = in_grant & ~(req_wr | req_rd);
    assign gnt_addr  = bus.agent_addr[int'(gnt)*SYS_MEM_ADDR_W +: SYS_MEM_ADDR_W];
    assign gnt_wdata = bus.agent_wdata[int'(gnt)*SYS_MEM_DATA_W +: SYS_MEM_DATA_W];

    // A full tag FIFO only blocks reads; writes stay eligible.
    assign eligible = bus.agent_wren | (bus.agent_rden & {NUM_AGENTS{count < FULL_CNT}});

    assign push = xfer_done & cmd_rd;
    assign pop  = bus.sys_mem_rd_valid & (count != '0);

    assign bus.sys_mem_wren  = in_grant & req_wr & ~rst;
    assign bus.sys_mem_rden  = in_grant & cmd_rd & ~rst;
    assign bus.sys_mem_addr  = in_grant ? gnt_addr  : addr_hold;
    assign bus.sys_mem_wdata = in_grant ? gnt_wdata : wdata_hold;
    assign bus.agent_rdata   = bus.sys_mem_rdata;
    assign rd_outstanding    = count;

    // Round-robin pick: first eligible agent after last_gnt, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_AGENTS; k++) begin
            cand = TAG_W'((int'(last_gnt) + k) % NUM_AGENTS);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Only the granted agent sees the memory stall; everyone else waits.
    always_comb begin
        bus.agent_wait = '1;
        if (in_grant && !rst) begin
            bus.agent_wait[gnt] = bus.sys_mem_wait;
        end
    end

    // Read-data strobe goes to the owner of the head tag.
    always_comb begin
        bus.agent_rd_valid = '0;
        if (pop && !rst) begin
            bus.agent_rd_valid[tag_mem[rd_ptr]] = 1'b1;
        end
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        last_gnt_nxt = last_gnt;
        if (!in_grant) begin
            if (found) begin
                state_nxt = GRANT;
                gnt_nxt   = pick;
            end
        end else if (abort) begin
            state_nxt = IDLE;
        end else if (xfer_done) begin
            state_nxt    = IDLE;
            last_gnt_nxt = gnt;
        end
    end

    // Controller state and held memory address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            last_gnt   <= TAG_W'(NUM_AGENTS - 1);
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            last_gnt <= last_gnt_nxt;
            if (in_grant) begin
                addr_hold  <= gnt_addr;
                wdata_hold <= gnt_wdata;
            end
        end
    end

    // Tag FIFO pointers, occupancy and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (bus.sys_mem_rd_valid && (count == '0)) rd_err <= 1'b1;
        end
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            tag_mem[wr_ptr] <= gnt;
        end
    end

endmodule

// File: tb/tb_sys_mem_arb.sv
// Self-checking bench for sys_mem_arb: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based transaction model.
module tb_sys_mem_arb;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int AW    = 27;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rd_outstanding;
    logic       rd_err;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sys_mem_arb_if #(.NUM_AGENTS(N), .SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW)) bus ();

    sys_mem_arb #(
        .NUM_AGENTS(N), .SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW), .RD_TAG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .rd_outstanding(rd_outstanding), .rd_err(rd_err)
    );

    // Reference model state
    bit              m_busy;
    int              m_gnt, m_last;
    int              q[$];
    bit              m_err;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.agent_wren = '0; bus.agent_rden = '0;
        bus.agent_addr = '0; bus.agent_wdata = '0;
        bus.sys_mem_wait = 1'b0; bus.sys_mem_rd_valid = 1'b0; bus.sys_mem_rdata = '0;
    endtask

    task automatic set_addr(input int a, input logic [AW-1:0] v);
        bus.agent_addr[a*AW +: AW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_last = N - 1; q.delete(); m_err = 0;
        m_addr = '0; m_wdata = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit wr, rd, do_push;
        int a;
        do_push = 0;
        if (m_busy) begin
            wr = bus.agent_wren[m_gnt];
            rd = bus.agent_rden[m_gnt];
            m_addr  = bus.agent_addr[m_gnt*AW +: AW];
            m_wdata = bus.agent_wdata[m_gnt*DW +: DW];
            if (!wr && !rd) m_busy = 0;
            else if (!bus.sys_mem_wait) begin
                m_busy = 0; m_last = m_gnt; do_push = !wr;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                a = (m_last + k) % N;
                if (bus.agent_wren[a] || (bus.agent_rden[a] && q.size() < DEPTH)) begin
                    m_busy = 1; m_gnt = a; break;
                end
            end
        end
        if (bus.sys_mem_rd_valid) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err = 1;
        end
        if (do_push) q.push_back(m_gnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        bus.agent_wren = 4'hF; bus.agent_rden = 4'hF; bus.sys_mem_rd_valid = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.agent_wait !== 4'hF) begin n_fail++; $display("FAIL rst_wait: got %b want 1111", bus.agent_wait); end
        n_cmp++; if ({bus.sys_mem_wren, bus.sys_mem_rden} !== 2'b00) begin n_fail++; $display("FAIL rst_cmd: got %b want 00", {bus.sys_mem_wren, bus.sys_mem_rden}); end
        n_cmp++; if (bus.agent_rd_valid !== 4'h0) begin n_fail++; $display("FAIL rst_rdv: got %b want 0000", bus.agent_rd_valid); end
        n_cmp++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL rst_outst: got %0d want 0", rd_outstanding); end
        n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", rd_err); end
        n_cmp++; if (bus.sys_mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.sys_mem_addr); end
        clr();
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        logic [AW-1:0] a0, a2, exp_a;
        logic [3:0]    exp_w;
        bit            even_g;
        do_reset();
        a0 = 27'h00000AA; a2 = 27'h00002BB;
        set_addr(0, a0); set_addr(2, a2);
        bus.agent_wren = 4'b0101;
        #1;
        for (int c = 0; c < 8; c++) begin
            even_g = ((c / 2) % 2) == 0;
            if (c % 2 == 1) begin
                exp_a = even_g ? a0 : a2;
                exp_w = even_g ? 4'b1110 : 4'b1011;
                n_cmp++; if (bus.sys_mem_wren !== 1'b1) begin n_fail++; $display("FAIL alt_wren c%0d: got %b want 1", c, bus.sys_mem_wren); end
                n_cmp++; if (bus.sys_mem_addr !== exp_a) begin n_fail++; $display("FAIL alt_addr c%0d: got %h want %h", c, bus.sys_mem_addr, exp_a); end
                n_cmp++; if (bus.agent_wait !== exp_w) begin n_fail++; $display("FAIL alt_wait c%0d: got %b want %b", c, bus.agent_wait, exp_w); end
            end else begin
                n_cmp++; if (bus.sys_mem_wren !== 1'b0) begin n_fail++; $display("FAIL alt_idle c%0d: got %b want 0", c, bus.sys_mem_wren); end
                n_cmp++; if (bus.agent_wait !== 4'hF) begin n_fail++; $display("FAIL alt_iwait c%0d: got %b want 1111", c, bus.agent_wait); end
                if (c > 0) begin
                    exp_a = (((c - 1) / 2) % 2 == 0) ? a0 : a2;
                    n_cmp++; if (bus.sys_mem_addr !== exp_a) begin n_fail++; $display("FAIL alt_hold c%0d: got %h want %h", c, bus.sys_mem_addr, exp_a); end
                end
            end
            tick();
        end
        clr();
    endtask

    task automatic test_read_wait();
        do_reset();
        set_addr(1, 27'h100);
        bus.agent_rden = 4'b0010;
        bus.sys_mem_wait = 1'b1;
        #1;
        n_cmp++; if (bus.sys_mem_rden !== 1'b0) begin n_fail++; $display("FAIL rw_idle: got %b want 0", bus.sys_mem_rden); end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.sys_mem_rden !== 1'b1) begin n_fail++; $display("FAIL rw_rden c%0d: got %b want 1", i, bus.sys_mem_rden); end
            n_cmp++; if (bus.agent_wait[1] !== 1'b1) begin n_fail++; $display("FAIL rw_wait c%0d: got %b want 1", i, bus.agent_wait[1]); end
            n_cmp++; if (bus.sys_mem_addr !== 27'h100) begin n_fail++; $display("FAIL rw_addr c%0d: got %h want 100", i, bus.sys_mem_addr); end
            tick();
        end
        bus.sys_mem_wait = 1'b0;
        #1;
        n_cmp++; if (bus.agent_wait !== 4'b1101) begin n_fail++; $display("FAIL rw_go: got %b want 1101", bus.agent_wait); end
        tick();
        bus.agent_rden = '0;
        #1;
        n_cmp++; if (rd_outstanding !== 4'd1) begin n_fail++; $display("FAIL rw_outst: got %0d want 1", rd_outstanding); end
        n_cmp++; if (bus.sys_mem_rden !== 1'b0) begin n_fail++; $display("FAIL rw_done: got %b want 0", bus.sys_mem_rden); end
        tick();
        tick();
        bus.sys_mem_rd_valid = 1'b1; bus.sys_mem_rdata = 32'hCAFE;
        #1;
        n_cmp++; if (bus.agent_rd_valid !== 4'b0010) begin n_fail++; $display("FAIL rw_rdv: got %b want 0010", bus.agent_rd_valid); end
        n_cmp++; if (bus.agent_rdata !== 32'hCAFE) begin n_fail++; $display("FAIL rw_rdata: got %h want cafe", bus.agent_rdata); end
        tick();
        bus.sys_mem_rd_valid = 1'b0;
        #1;
        n_cmp++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL rw_drain: got %0d want 0", rd_outstanding); end
        n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL rw_err: got %b want 0", rd_err); end
        clr();
    endtask

    task automatic test_fifo_full();
        int guard;
        do_reset();
        bus.agent_rden = 4'b1000;
        #1;
        guard = 0;
        while (rd_outstanding !== 4'd8 && guard < 40) begin
            tick();
            guard++;
        end
        n_cmp++; if (rd_outstanding !== 4'd8) begin n_fail++; $display("FAIL full_fill: got %0d want 8 within 40 cycles", rd_outstanding); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.sys_mem_rden !== 1'b0) begin n_fail++; $display("FAIL full_block c%0d: got %b want 0", i, bus.sys_mem_rden); end
            n_cmp++; if (bus.agent_wait[3] !== 1'b1) begin n_fail++; $display("FAIL full_wait c%0d: got %b want 1", i, bus.agent_wait[3]); end
        end
        bus.agent_wren = 4'b0001;
        set_addr(0, 27'h55);
        tick();
        n_cmp++; if (bus.sys_mem_wren !== 1'b1) begin n_fail++; $display("FAIL full_wr: got %b want 1", bus.sys_mem_wren); end
        n_cmp++; if (bus.sys_mem_addr !== 27'h55) begin n_fail++; $display("FAIL full_wraddr: got %h want 55", bus.sys_mem_addr); end
        tick();
        bus.agent_wren = '0;
        bus.sys_mem_rd_valid = 1'b1;
        #1;
        n_cmp++; if (bus.agent_rd_valid !== 4'b1000) begin n_fail++; $display("FAIL full_rdv: got %b want 1000", bus.agent_rd_valid); end
        tick();
        bus.sys_mem_rd_valid = 1'b0;
        #1;
        n_cmp++; if (rd_outstanding !== 4'd7) begin n_fail++; $display("FAIL full_pop: got %0d want 7", rd_outstanding); end
        tick();
        n_cmp++; if (bus.sys_mem_rden !== 1'b1) begin n_fail++; $display("FAIL full_9th: got %b want 1", bus.sys_mem_rden); end
        n_cmp++; if (bus.agent_wait !== 4'b0111) begin n_fail++; $display("FAIL full_9wait: got %b want 0111", bus.agent_wait); end
        tick();
        bus.agent_rden = '0;
        #1;
        n_cmp++; if (rd_outstanding !== 4'd8) begin n_fail++; $display("FAIL full_refill: got %0d want 8", rd_outstanding); end
        clr();
    endtask

    task automatic issue_read(input int a);
        bus.agent_rden = '0;
        bus.agent_rden[a] = 1'b1;
        tick();
        tick();
        bus.agent_rden = '0;
    endtask

    task automatic test_order();
        int          order[3];
        logic [3:0]  exp_v;
        logic [DW-1:0] d;
        order = '{2, 0, 3};
        do_reset();
        for (int j = 0; j < 3; j++) issue_read(order[j]);
        #1;
        n_cmp++; if (rd_outstanding !== 4'd3) begin n_fail++; $display("FAIL ord_outst: got %0d want 3", rd_outstanding); end
        for (int j = 0; j < 3; j++) begin
            d = $urandom;
            exp_v = 4'b0001 << order[j];
            bus.sys_mem_rd_valid = 1'b1; bus.sys_mem_rdata = d;
            #1;
            n_cmp++; if (bus.agent_rd_valid !== exp_v) begin n_fail++; $display("FAIL ord_rdv%0d: got %b want %b", j, bus.agent_rd_valid, exp_v); end
            n_cmp++; if (bus.agent_rdata !== d) begin n_fail++; $display("FAIL ord_data%0d: got %h want %h", j, bus.agent_rdata, d); end
            tick();
            bus.sys_mem_rd_valid = 1'b0;
        end
        #1;
        n_cmp++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL ord_empty: got %0d want 0", rd_outstanding); end
        clr();
    endtask

    task automatic test_empty_return();
        do_reset();
        bus.sys_mem_rd_valid = 1'b1;
        #1;
        n_cmp++; if (bus.agent_rd_valid !== 4'h0) begin n_fail++; $display("FAIL emp_rdv: got %b want 0000", bus.agent_rd_valid); end
        tick();
        bus.sys_mem_rd_valid = 1'b0;
        #1;
        n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL emp_err: got %b want 1", rd_err); end
        n_cmp++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL emp_outst: got %0d want 0", rd_outstanding); end
        tick();
        tick();
        n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL emp_sticky: got %b want 1", rd_err); end
        clr();
    endtask

    task automatic test_reset_grant();
        do_reset();
        issue_read(1);
        issue_read(2);
        #1;
        n_cmp++; if (rd_outstanding !== 4'd2) begin n_fail++; $display("FAIL rg_outst: got %0d want 2", rd_outstanding); end
        bus.agent_rden = 4'b0001;
        bus.sys_mem_wait = 1'b1;
        tick();
        n_cmp++; if (bus.sys_mem_rden !== 1'b1) begin n_fail++; $display("FAIL rg_grant: got %b want 1", bus.sys_mem_rden); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.agent_wait !== 4'hF) begin n_fail++; $display("FAIL rg_rstwait: got %b want 1111", bus.agent_wait); end
        n_cmp++; if (bus.sys_mem_rden !== 1'b0) begin n_fail++; $display("FAIL rg_rstcmd: got %b want 0", bus.sys_mem_rden); end
        tick();
        rst = 1'b0;
        bus.sys_mem_wait = 1'b0;
        #1;
        n_cmp++; if (bus.agent_wait !== 4'hF) begin n_fail++; $display("FAIL rg_idle: got %b want 1111", bus.agent_wait); end
        n_cmp++; if (bus.sys_mem_rden !== 1'b0) begin n_fail++; $display("FAIL rg_cmd: got %b want 0", bus.sys_mem_rden); end
        n_cmp++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL rg_outst0: got %0d want 0", rd_outstanding); end
        n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL rg_err0: got %b want 0", rd_err); end
        bus.agent_rden = '0;
        bus.sys_mem_rd_valid = 1'b1;
        #1;
        n_cmp++; if (bus.agent_rd_valid !== 4'h0) begin n_fail++; $display("FAIL rg_rdv: got %b want 0000", bus.agent_rd_valid); end
        tick();
        bus.sys_mem_rd_valid = 1'b0;
        #1;
        n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL rg_err: got %b want 1", rd_err); end
        clr();
    endtask

    task automatic test_random(input int cycles);
        logic          exp_wr, exp_rd;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        logic [3:0]    exp_wait, exp_rdv;
        do_reset();
        model_reset();
        for (int c = 0; c < cycles; c++) begin
            bus.agent_wren = 4'($urandom) & 4'($urandom);
            bus.agent_rden = 4'($urandom);
            for (int a = 0; a < N; a++) begin
                set_addr(a, AW'($urandom));
                bus.agent_wdata[a*DW +: DW] = $urandom;
            end
            bus.sys_mem_wait     = ($urandom_range(0, 3) == 0);
            bus.sys_mem_rd_valid = ($urandom_range(0, 2) == 0);
            bus.sys_mem_rdata    = $urandom;
            #1;
            exp_wr   = m_busy && bus.agent_wren[m_gnt];
            exp_rd   = m_busy && bus.agent_rden[m_gnt] && !bus.agent_wren[m_gnt];
            exp_addr = m_busy ? bus.agent_addr[m_gnt*AW +: AW] : m_addr;
            exp_wd   = m_busy ? bus.agent_wdata[m_gnt*DW +: DW] : m_wdata;
            exp_wait = 4'hF;
            if (m_busy) exp_wait[m_gnt] = bus.sys_mem_wait;
            exp_rdv = 4'h0;
            if (bus.sys_mem_rd_valid && q.size() > 0) exp_rdv[q[0]] = 1'b1;
            n_cmp++; if ({bus.sys_mem_wren, bus.sys_mem_rden} !== {exp_wr, exp_rd}) begin n_fail++; $display("FAIL rnd_cmd c%0d: got %b want %b", c, {bus.sys_mem_wren, bus.sys_mem_rden}, {exp_wr, exp_rd}); end
            n_cmp++; if (bus.sys_mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.sys_mem_addr, exp_addr); end
            n_cmp++; if (bus.sys_mem_wdata !== exp_wd) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, bus.sys_mem_wdata, exp_wd); end
            n_cmp++; if (bus.agent_wait !== exp_wait) begin n_fail++; $display("FAIL rnd_wait c%0d: got %b want %b", c, bus.agent_wait, exp_wait); end
            n_cmp++; if (bus.agent_rd_valid !== exp_rdv) begin n_fail++; $display("FAIL rnd_rdv c%0d: got %b want %b", c, bus.agent_rd_valid, exp_rdv); end
            n_cmp++; if (rd_outstanding !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_outst c%0d: got %0d want %0d", c, rd_outstanding, q.size()); end
            n_cmp++; if (rd_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, rd_err, m_err); end
            n_cmp++; if (bus.agent_rdata !== bus.sys_mem_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, bus.agent_rdata, bus.sys_mem_rdata); end
            model_step();
            tick();
        end
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr();
        test_reset();
        test_alternate();
        test_read_wait();
        test_fifo_full();
        test_order();
        test_empty_return();
        test_reset_grant();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
